pulse_fifo_reader: RTL and testbench
====================================

Name: pulse_fifo_reader

Overview:
- Read-side consumer of the 64-bit photon-pulse record FIFO; the pulse counter is the writer (64-bit writedata plus write strobe).
- Pops one 64-bit record at a time from a show-ahead FIFO into a holding register.
- Exposes the held record to the HPS lightweight bridge as a 32-bit Avalon-MM slave: status, data low, data high and a consumed-record count.
- Reading DATA_HI consumes the record. A software flush drains the FIFO.

Parameters:
DATA_W, 64, FIFO record width; fixed at 64 (split into two 32-bit words)
CNT_W, 32, width of consumed-record counter; wraps modulo 2^CNT_W

Ports:
clk  in  1  system clock; all logic rising-edge
reset_n  in  1  asynchronous active-low reset
fifo_readdata  in  64  show-ahead FIFO head word; valid whenever fifo_empty=0
fifo_empty  in  1  FIFO empty flag
fifo_read  out  1  FIFO pop strobe; one word removed per cycle asserted
avs_address  in  2  register select: 0 STATUS, 1 DATA_LO, 2 DATA_HI, 3 COUNT
avs_read  in  1  Avalon read strobe
avs_write  in  1  Avalon write strobe
avs_writedata  in  32  write data; only STATUS is writable
avs_readdata  out  32  read data; valid the cycle after avs_read (fixed latency 1)
avs_readdatavalid  out  1  registered copy of avs_read
irq  out  1  level interrupt: holding register valid

Behaviour:
- Reset (async, reset_n=0):
  - state=S_EMPTY; hold=0; shadow_hi=0.
  - count=0; underflow=0.
  - avs_readdata=0; avs_readdatavalid=0; irq=0.
  - fifo_read is 0 during reset.
  - Reset mid-drain or mid-read discards the held record and any pending read.
- States S_EMPTY, S_FULL, S_FLUSH; 2-bit encoding, state register only.
- fifo_read is combinational from the registered state and fifo_empty: 1 when (S_EMPTY or S_FLUSH) and fifo_empty=0. It is never asserted when fifo_empty=1.
- S_EMPTY:
  - If fifo_empty=0: hold<=fifo_readdata on the same edge that pops; go to S_FULL.
  - Otherwise stay.
- S_FULL:
  - A DATA_HI read returns hold[63:32] and pops. On the next edge: count<=count+1, state<=S_EMPTY.
  - Refill occurs no earlier than the cycle after that edge, so there is no bypass. Minimum 2 cycles between consecutive records.
- S_FLUSH:
  - Pop and discard every cycle while fifo_empty=0.
  - Go to S_EMPTY on the first cycle with fifo_empty=1 (that cycle has no pop).
  - Words written into the FIFO during the flush are discarded while they arrive before exit.
- STATUS read:
  - bit0 = (state==S_FULL); bit1 = underflow; bit2 = (state==S_FLUSH); bit3 = fifo_empty.
  - All other bits are 0.
- DATA_LO read:
  - In S_FULL: returns hold[31:0] and latches shadow_hi<=hold[63:32].
  - Otherwise: returns 0 and shadow_hi is unchanged.
- DATA_HI read:
  - In S_FULL: returns hold[63:32] and consumes the record. The direct hold value is authoritative; shadow_hi is informational only and equals hold[63:32] whenever S_FULL.
  - Not in S_FULL: returns 0, sets underflow=1 (sticky) and pops nothing.
- COUNT read returns count; it wraps 0xFFFFFFFF to 0 without saturating.
- STATUS write:
  - If writedata[0]=1: state<=S_FLUSH, discarding hold (hold<=0), count<=0 and underflow<=0.
  - If writedata[1]=1 (and bit0=0): clear underflow only.
  - Writes to other addresses are ignored.
- Simultaneous avs_read and avs_write: the write takes effect and the read returns 0 with readdatavalid still asserted. This is a bridge protocol violation and must be tolerated, not relied on.
- avs_readdata is registered. It returns the value sampled at the edge where avs_read=1, i.e. the pre-update state; for example, STATUS read in the same cycle as a refill returns bit0=0.
- irq is registered: equals (next state==S_FULL), so it follows state with no extra latency.

Test Plan:
- FIFO holds 0x1122334455667788, bench reads LO then HI -> fifo_read exactly 1 cycle; LO=0x55667788; HI=0x11223344; COUNT=1; irq falls after the HI read.
- Three records queued back-to-back, drained by LO/HI pairs -> data returned in FIFO order; COUNT=3; no pop while S_FULL; fifo_read never asserted with fifo_empty=1.
- DATA_HI read with FIFO empty -> readdata=0; STATUS=0x0000000A (underflow=1, fifo_empty=1); writing 0x2 to STATUS clears it to 0x8.
- 5 words queued, flush written (0x1) -> 5 consecutive fifo_read cycles; STATUS bit2=1 during the drain and 0 after; COUNT=0; then a new word 0xA5 refills normally.
- reset_n pulsed low while in S_FULL with COUNT=7 -> all outputs 0 immediately (async); after release the state refills from the FIFO head; COUNT=0.
- Preload COUNT to 0xFFFFFFFF via 2^32−1 pops (or force), then consume one record -> COUNT=0.

Source files
------------

// File: rtl/pulse_fifo_reader_if.sv
// Bundle between pulse_fifo_reader, its show-ahead record FIFO and the lightweight-bridge slave port.
interface pulse_fifo_reader_if;
  logic [63:0] fifo_readdata;
  logic        fifo_empty;
  logic        fifo_read;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;
  logic [31:0] shadow_hi;

  modport slave (
    input  fifo_readdata, fifo_empty, avs_address, avs_read, avs_write, avs_writedata,
    output fifo_read, avs_readdata, avs_readdatavalid, irq, shadow_hi
  );

  modport master (
    output fifo_readdata, fifo_empty, avs_address, avs_read, avs_write, avs_writedata,
    input  fifo_read, avs_readdata, avs_readdatavalid, irq, shadow_hi
  );
endinterface

// File: rtl/pulse_fifo_reader.sv
// Pops 64-bit photon-pulse records from a show-ahead FIFO into a holding register and
// serves them as two 32-bit Avalon-MM words; reading DATA_HI consumes the record.
//   state   | meaning
//   S_EMPTY | no record held, pop the FIFO head as soon as one appears
//   S_FULL  | record held, waiting for software to read DATA_HI
//   S_FLUSH | software flush, pop and discard until the FIFO reads empty
module pulse_fifo_reader #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input logic              clk,
  input logic              reset_n,
  pulse_fifo_reader_if.slave bus
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_LO     = 2'd1;
  localparam logic [1:0] A_HI     = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  logic [1:0]        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_hold, w_hold_nxt;
  logic [31:0]       r_shadow_hi, w_shadow_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_underflow, w_underflow_nxt;
  logic [31:0]       r_readdata, w_readdata_nxt;
  logic              r_readdatavalid;
  logic              r_irq;

  logic w_full, w_rd, w_rd_lo, w_rd_hi, w_wr_status, w_flush, w_clr_uf;
  logic w_unused_wdata;

  assign w_full      = (r_state == S_FULL);
  // A read colliding with a write is answered with zero and has no side effects
  assign w_rd        = bus.avs_read & ~bus.avs_write;
  assign w_rd_lo     = w_rd & (bus.avs_address == A_LO);
  assign w_rd_hi     = w_rd & (bus.avs_address == A_HI);
  assign w_wr_status = bus.avs_write & (bus.avs_address == A_STATUS);
  assign w_flush     = w_wr_status & bus.avs_writedata[0];
  assign w_clr_uf    = w_wr_status & bus.avs_writedata[1];
  assign w_unused_wdata = ^bus.avs_writedata[31:2];

  assign bus.fifo_read = reset_n & ~bus.fifo_empty &
                         ((r_state == S_EMPTY) | (r_state == S_FLUSH));

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_shadow_nxt    = r_shadow_hi;
    w_count_nxt     = r_count;
    w_underflow_nxt = r_underflow;
    if (w_flush) begin
      w_state_nxt     = S_FLUSH;
      w_hold_nxt      = '0;
      w_count_nxt     = '0;
      w_underflow_nxt = 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (!bus.fifo_empty) begin
            w_state_nxt  = S_FULL;
            w_hold_nxt   = bus.fifo_readdata;
            w_shadow_nxt = bus.fifo_readdata[63:32];
          end
        end
        S_FULL: begin
          if (w_rd_lo) w_shadow_nxt = r_hold[DATA_W-1:32];
          if (w_rd_hi) begin
            w_state_nxt = S_EMPTY;
            w_count_nxt = r_count + 1'b1;
          end
        end
        S_FLUSH: begin
          if (bus.fifo_empty) w_state_nxt = S_EMPTY;
        end
        default: w_state_nxt = S_EMPTY;
      endcase
      if (w_rd_hi && !w_full) w_underflow_nxt = 1'b1;
      if (w_clr_uf)           w_underflow_nxt = 1'b0;
    end
  end

  always_comb begin
    w_readdata_nxt = '0;
    if (w_rd) begin
      case (bus.avs_address)
        A_STATUS: w_readdata_nxt = {28'd0, bus.fifo_empty, (r_state == S_FLUSH), r_underflow, w_full};
        A_LO:     w_readdata_nxt = w_full ? r_hold[31:0] : 32'd0;
        A_HI:     w_readdata_nxt = w_full ? r_hold[DATA_W-1:32] : 32'd0;
        A_COUNT:  w_readdata_nxt = 32'(r_count);
        default:  w_readdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_EMPTY;
      r_hold          <= '0;
      r_shadow_hi     <= '0;
      r_count         <= '0;
      r_underflow     <= 1'b0;
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
      r_irq           <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_hold          <= w_hold_nxt;
      r_shadow_hi     <= w_shadow_nxt;
      r_count         <= w_count_nxt;
      r_underflow     <= w_underflow_nxt;
      r_readdata      <= w_readdata_nxt;
      r_readdatavalid <= bus.avs_read;
      r_irq           <= (w_state_nxt == S_FULL);
    end
  end

  assign bus.avs_readdata      = r_readdata;
  assign bus.avs_readdatavalid = r_readdatavalid;
  assign bus.irq               = r_irq;
  assign bus.shadow_hi         = r_shadow_hi;

endmodule

// File: tb/tb_pulse_fifo_reader.sv
// Scoreboard bench: a queue-based FIFO and a record-level reference model predict every read response.
module tb_pulse_fifo_reader;
  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pulse_fifo_reader_if bus();
  pulse_fifo_reader #(.DATA_W(64), .CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  int n_pops = 0;
  logic [63:0] fifo_q[$];
  logic [31:0] exp_q[$];

  // reference model: one held record or none, a flush flag, sticky underflow, modular count
  bit          m_full, m_flush, m_uf;
  logic [63:0] m_hold;
  int          m_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty    = (fifo_q.size() == 0);
    bus.fifo_readdata = (fifo_q.size() != 0) ? fifo_q[0] : 64'hDEAD_BEEF_0BAD_F00D;
  endtask

  task automatic push(input logic [63:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  task automatic model_reset();
    m_full = 0; m_flush = 0; m_uf = 0; m_hold = '0; m_count = 0;
    exp_q.delete();
  endtask

  // called at posedge+1; returns at the following posedge+1
  task automatic step(input bit rd, input logic [1:0] a, input bit wr, input logic [31:0] wd);
    bit empty_now, exp_pop, hi_rd, act_pop;
    logic [63:0] head;
    logic [31:0] exp_rd;
    bus.avs_read = rd; bus.avs_address = a; bus.avs_write = wr; bus.avs_writedata = wd;
    #1;
    empty_now = (fifo_q.size() == 0);
    head      = empty_now ? 64'd0 : fifo_q[0];
    exp_pop   = !empty_now && !m_full;
    check("fifo_read", {63'd0, bus.fifo_read}, {63'd0, exp_pop});
    if (rd) begin
      exp_rd = 32'd0;
      if (!wr) begin
        case (a)
          2'd0: exp_rd = {28'd0, empty_now, m_flush, m_uf, m_full};
          2'd1: exp_rd = m_full ? m_hold[31:0] : 32'd0;
          2'd2: exp_rd = m_full ? m_hold[63:32] : 32'd0;
          default: exp_rd = 32'(m_count);
        endcase
      end
      exp_q.push_back(exp_rd);
    end
    hi_rd = rd && !wr && (a == 2'd2);
    if (wr && a == 2'd0 && wd[0]) begin
      m_flush = 1; m_full = 0; m_hold = '0; m_count = 0; m_uf = 0;
    end else begin
      if (hi_rd && !m_full) m_uf = 1;
      if (wr && a == 2'd0 && wd[1]) m_uf = 0;
      if (m_full) begin
        if (hi_rd) begin m_full = 0; m_count = (m_count + 1) % CMOD; end
      end else if (m_flush) begin
        if (empty_now) m_flush = 0;
      end else if (!empty_now) begin
        m_full = 1; m_hold = head;
      end
    end
    act_pop = bus.fifo_read;
    @(posedge clk); #1;
    if (act_pop && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      n_pops++;
    end
    drive_fifo();
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    check("irq", {63'd0, bus.irq}, {63'd0, m_full});
    if (m_full) check("shadow_hi", {32'd0, bus.shadow_hi}, {32'd0, m_hold[63:32]});
  endtask

  task automatic idle();        step(0, 2'd0, 0, 32'd0); endtask
  task automatic rd(input logic [1:0] a); step(1, a, 0, 32'd0); endtask
  task automatic wr_status(input logic [31:0] d); step(0, 2'd0, 1, d); endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1;
    check("rst_irq", {63'd0, bus.irq}, 64'd0);
    check("rst_rdvalid", {63'd0, bus.avs_readdatavalid}, 64'd0);
    check("rst_rdata", {32'd0, bus.avs_readdata}, 64'd0);
    check("rst_fifo_read", {63'd0, bus.fifo_read}, 64'd0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (bus.avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_readdatavalid: got data %h, expected no response", bus.avs_readdata);
      end else begin
        check("readdata", {32'd0, bus.avs_readdata}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] wd;
    bus.avs_read = 0; bus.avs_write = 0; bus.avs_address = 0; bus.avs_writedata = 0;
    model_reset();
    push(64'h1122_3344_5566_7788);
    #2;
    check("por_fifo_read", {63'd0, bus.fifo_read}, 64'd0);
    check("por_irq", {63'd0, bus.irq}, 64'd0);
    check("por_rdata", {32'd0, bus.avs_readdata}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // single record, LO then HI
    n_pops = 0;
    idle(); rd(2'd1); rd(2'd2); idle(); rd(2'd3);
    check("single_pops", 64'(n_pops), 64'd1);

    // three back-to-back records
    n_pops = 0;
    push(64'hAAAA_0001_BBBB_0001); push(64'hAAAA_0002_BBBB_0002); push(64'hAAAA_0003_BBBB_0003);
    for (int i = 0; i < 3; i++) begin idle(); rd(2'd1); rd(2'd2); end
    rd(2'd3);
    check("three_pops", 64'(n_pops), 64'd3);

    // underflow and its clear
    rd(2'd2); rd(2'd0); wr_status(32'h2); rd(2'd0);

    // flush of five queued words
    for (int i = 0; i < 5; i++) fifo_q.push_back(64'h5000 + 64'(i));
    drive_fifo();
    n_pops = 0;
    wr_status(32'h1);
    for (int i = 0; i < 6; i++) rd(2'd0);
    check("flush_pops", 64'(n_pops), 64'd5);
    rd(2'd3);
    push(64'hA5);
    idle(); rd(2'd1); rd(2'd2);

    // reset while holding a record with COUNT=7 and a read in flight
    wr_status(32'h1); idle();
    for (int i = 0; i < 7; i++) begin push({$urandom, $urandom}); idle(); rd(2'd2); end
    push(64'hCAFE_0000_F00D_0007); idle();
    push(64'h0123_4567_89AB_CDEF);
    rd(2'd3);
    do_reset();
    idle(); rd(2'd1); rd(2'd3); rd(2'd2);

    // counter wrap at 2^CNT_W consumed records
    push(64'h77); idle();
    for (int i = 0; i < CMOD; i++) begin push({$urandom, $urandom}); idle(); rd(2'd2); end
    rd(2'd3);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 40 && fifo_q.size() < 8) push({$urandom, $urandom});
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) wd[0] = 1'b0;
      step(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0), wd);
    end

    idle(); idle(); idle();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
